uart_tx_ctrl: RTL and testbench

//  Transmit-side controller and serializer for the UART, the TX counterpart of the RX frame FSM.

---
 rtl/uart_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   Transmit-side frame controller and serializer for the UART. It accepts
//   parallel words over a valid/ready handshake and holds one pending word.
//   It puts start, data (LSB first), optional parity and stop bits on tx_out,
//   one bit per clk. clk is the TX baud clock.
//
// Ports
//   clk         in   TX baud clock; all state updates on posedge
//   rst         in   asynchronous, active-low reset
//   p_data      in   parallel word to transmit
//   data_valid  in   p_data is offered this cycle
//   data_ready  out  combinational; high when the hold buffer is empty
//   par_en      in   1 = insert parity bit; sampled when a frame loads
//   par_typ     in   0 = even, 1 = odd; sampled when a frame loads
//   tx_out      out  serial line, registered, idle high
//   busy        out  registered; high while a frame is on the line
//   tx_done     out  registered; high during the STOP bit cycle
//   o_dbg_state out  current FSM state (debug visibility)
//
// Handshake: a word transfers on every posedge where data_valid and
// data_ready are both high. data_ready depends only on internal state, never
// on data_valid. While data_ready is low, data_valid is ignored and p_data is
// not sampled.
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done,
    output logic [2:0]            o_dbg_state
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic w_accept;
    logic w_mid_frame;

    assign data_ready  = ~r_hold_full;
    assign w_accept    = data_valid & ~r_hold_full;
    // Words accepted in these states go to the hold buffer; STOP bypasses
    // straight into the shifter and IDLE loads the shifter directly.
    assign w_mid_frame = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY);

    assign tx_out      = r_tx;
    assign busy        = r_busy;
    assign tx_done     = r_done;
    assign o_dbg_state = r_state;

    // Outputs are registered and set on the edge that enters a state, so
    // tx_out always shows the bit belonging to the current state. The parity
    // bit is computed once at frame load from the captured word and par_typ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= p_data;
                        r_par_en  <= par_en;
                        r_par_bit <= (^p_data) ^ par_typ;
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    r_state   <= S_DATA;
                    r_bit_cnt <= '0;
                    r_tx      <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                end
                S_DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        if (r_par_en) begin
                            r_state <= S_PARITY;
                            r_tx    <= r_par_bit;
                        end else begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                end
                S_PARITY: begin
                    r_state <= S_STOP;
                    r_tx    <= 1'b1;
                    r_done  <= 1'b1;
                end
                S_STOP: begin
                    r_done <= 1'b0;
                    if (r_hold_full) begin
                        // Held word wins; data_ready is low so nothing new enters.
                        r_shift     <= r_hold;
                        r_par_en    <= par_en;
                        r_par_bit   <= (^r_hold) ^ par_typ;
                        r_hold_full <= 1'b0;
                        r_state     <= S_START;
                        r_tx        <= 1'b0;
                    end else if (data_valid) begin
                        r_shift   <= p_data;
                        r_par_en  <= par_en;
                        r_par_bit <= (^p_data) ^ par_typ;
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

            if (w_accept && w_mid_frame) begin
                r_hold      <= p_data;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Bench for uart_tx_ctrl. The reference model holds the upcoming line
//   symbols as a queue of {tx, done} pairs built from whole frames, plus a
//   single held word. Directed scenarios pin the model with literal values;
//   a random phase then runs against the model.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       data_ready;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;
    logic       tx_done;
    logic [2:0] dbg_state;

    int total;
    int bad;
    bit chk_en;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q[0] is the symbol on the line in the current cycle; empty = idle.
    logic [1:0] exp_q[$];
    logic       held_v;
    logic [7:0] held_w;
    logic       acc;

    task automatic push_frame(input logic [7:0] w);
        exp_q.push_back(2'b00);
        for (int i = 0; i < 8; i++) exp_q.push_back({w[i], 1'b0});
        if (par_en) exp_q.push_back({(^w) ^ par_typ, 1'b0});
        exp_q.push_back(2'b11);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            held_v = 1'b0;
            held_w = 8'h00;
        end else begin
            acc = data_valid && !held_v;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                if (held_v) begin
                    push_frame(held_w);
                    held_v = 1'b0;
                end else if (acc) begin
                    push_frame(p_data);
                end
            end else if (acc) begin
                held_v = 1'b1;
                held_w = p_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst === 1'b1) begin
            chk("m_tx",    tx_out,     (exp_q.size() > 0) ? exp_q[0][1] : 1'b1);
            chk("m_busy",  busy,       exp_q.size() > 0);
            chk("m_done",  tx_done,    (exp_q.size() > 0) ? exp_q[0][0] : 1'b0);
            chk("m_ready", data_ready, !held_v);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [7:0] w, input logic pe, input logic pt,
                              input int len, output logic [15:0] bits);
        bits = '0;
        @(negedge clk);
        p_data = w; par_en = pe; par_typ = pt; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        p_data = 8'($urandom_range(0, 255));
        for (int k = 0; k < len; k++) begin
            bits[k] = tx_out;
            chk("frame_busy", busy, 1'b1);
            chk("frame_done", tx_done, (k == len - 1));
            @(negedge clk);
        end
        chk("after_tx", tx_out, 1'b1);
        chk("after_busy", busy, 1'b0);
    endtask

    logic [15:0] b;
    logic [24:0] rec_tx;
    logic [24:0] rec_b;
    logic [24:0] rec_d;

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        rst = 1'b0; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_ready", data_ready, 1'b1);
        #2 rst = 1'b1;
        chk_en = 1'b1;

        // 1) plain frame
        send_frame(8'hA5, 1'b0, 1'b0, 10, b);
        chk("t1_bits", b[9:0], 10'b1101001010);

        // 2) parity frames
        send_frame(8'hA5, 1'b1, 1'b0, 11, b);
        chk("t2_even_a5", b[9], 1'b0);
        chk("t2_data_a5", b[8:1], 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1, 11, b);
        chk("t2_odd_a5", b[9], 1'b1);
        send_frame(8'h01, 1'b1, 1'b0, 11, b);
        chk("t2_even_01", b[9], 1'b1);

        // 3/4) back-to-back via hold, then hold-full refusal
        @(negedge clk);
        p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            rec_tx[k] = tx_out; rec_b[k] = busy; rec_d[k] = tx_done;
            if (k >= 2 && k <= 6) chk("t4_ready_low", data_ready, 1'b0);
            if (k == 1) begin
                data_valid = 1'b1; p_data = 8'h0F;
            end else if (k >= 2 && k <= 6) begin
                data_valid = 1'b1; p_data = 8'hFF;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("t3_busy20", rec_b[19:0], 20'hFFFFF);
        chk("t3_idle", rec_b[20], 1'b0);
        chk("t3_w1", rec_tx[8:1], 8'h55);
        chk("t3_stop1", rec_tx[9], 1'b1);
        chk("t3_start2", rec_tx[10], 1'b0);
        chk("t3_w2", rec_tx[18:11], 8'h0F);
        chk("t4_no_ff", rec_tx[24:20], 5'h1F);

        // 5) bypass in STOP and mid-frame par_en toggling
        @(negedge clk);
        p_data = 8'h81; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k < 23; k++) begin
            rec_tx[k] = tx_out; rec_b[k] = busy; rec_d[k] = tx_done;
            if (k == 9) chk("t5_stop_ready", data_ready, 1'b1);
            if (k == 3) par_en = 1'b1;
            if (k == 6) par_en = 1'b0;
            if (k == 9) begin
                data_valid = 1'b1; p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b0;
            end
            if (k == 10) begin
                data_valid = 1'b0; p_data = 8'($urandom_range(0, 255));
            end
            if (k == 13) par_en = 1'b0;
            @(negedge clk);
        end
        chk("t5_done1", rec_d[9:0], 10'b1000000000);
        chk("t5_start2", rec_tx[10], 1'b0);
        chk("t5_busy", rec_b[20:0], 21'h1FFFFF);
        chk("t5_w2", rec_tx[18:11], 8'h3C);
        chk("t5_par", rec_tx[19], 1'b0);
        chk("t5_done2", rec_d[20], 1'b1);
        chk("t5_idle", rec_b[21], 1'b0);

        // 6) reset during DATA bit 3 with a held word
        @(negedge clk);
        p_data = 8'hC3; par_en = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                data_valid = 1'b1; p_data = 8'h77;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        chk("t6_tx", tx_out, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", tx_done, 1'b0);
        chk("t6_ready", data_ready, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("t6_quiet_busy", busy, 1'b0);
            chk("t6_quiet_tx", tx_out, 1'b1);
        end

        // random phase
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            data_valid = ($urandom_range(0, 2) == 0);
            p_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) par_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) par_typ = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
